// File: rtl/reservation_station_if.sv
// Signal bundles around the reservation station: dispatcher side, CDB snoop and
// functional-unit issue port.

interface rs_dispatch_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6
);
  logic                  i_rs_en;
  logic [6:0]            i_rs_opcode;
  logic [ADDR_WIDTH-1:0] i_rs_iaddr;
  logic [DATA_WIDTH-1:0] i_rs_insn;
  logic [TAG_WIDTH-1:0]  i_rs_src_tag0;
  logic [TAG_WIDTH-1:0]  i_rs_src_tag1;
  logic [DATA_WIDTH-1:0] i_rs_src_data0;
  logic [DATA_WIDTH-1:0] i_rs_src_data1;
  logic                  i_rs_src_rdy0;
  logic                  i_rs_src_rdy1;
  logic [TAG_WIDTH-1:0]  i_rs_dst_tag;
  logic                  o_rs_stall;

  modport master (
    output i_rs_en, i_rs_opcode, i_rs_iaddr, i_rs_insn,
    output i_rs_src_tag0, i_rs_src_tag1, i_rs_src_data0, i_rs_src_data1,
    output i_rs_src_rdy0, i_rs_src_rdy1, i_rs_dst_tag,
    input  o_rs_stall
  );
  modport slave (
    input  i_rs_en, i_rs_opcode, i_rs_iaddr, i_rs_insn,
    input  i_rs_src_tag0, i_rs_src_tag1, i_rs_src_data0, i_rs_src_data1,
    input  i_rs_src_rdy0, i_rs_src_rdy1, i_rs_dst_tag,
    output o_rs_stall
  );
endinterface

interface rs_cdb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6
);
  logic                  i_cdb_en;
  logic [TAG_WIDTH-1:0]  i_cdb_tag;
  logic [DATA_WIDTH-1:0] i_cdb_data;
  logic                  i_cdb_redirect;

  modport master (output i_cdb_en, i_cdb_tag, i_cdb_data, i_cdb_redirect);
  modport slave  (input  i_cdb_en, i_cdb_tag, i_cdb_data, i_cdb_redirect);
endinterface

interface rs_funit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6
);
  logic                  o_fu_valid;
  logic [6:0]            o_fu_opcode;
  logic [ADDR_WIDTH-1:0] o_fu_iaddr;
  logic [DATA_WIDTH-1:0] o_fu_insn;
  logic [DATA_WIDTH-1:0] o_fu_src_a;
  logic [DATA_WIDTH-1:0] o_fu_src_b;
  logic [TAG_WIDTH-1:0]  o_fu_tag;
  logic                  i_fu_stall;

  modport master (
    output o_fu_valid, o_fu_opcode, o_fu_iaddr, o_fu_insn,
    output o_fu_src_a, o_fu_src_b, o_fu_tag,
    input  i_fu_stall
  );
  modport slave (
    input  o_fu_valid, o_fu_opcode, o_fu_iaddr, o_fu_insn,
    input  o_fu_src_a, o_fu_src_b, o_fu_tag,
    output i_fu_stall
  );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched instructions, snoops the CDB for
// outstanding operands and issues the lowest-index ready entry each cycle.

module reservation_station #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6,
  parameter int unsigned RS_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  rs_dispatch_if.slave  disp,
  rs_cdb_if.slave       cdb,
  rs_funit_if.master    fu
);

  localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int unsigned OPC_W = 7;

  typedef struct packed {
    logic [OPC_W-1:0]      opcode;
    logic [ADDR_WIDTH-1:0] iaddr;
    logic [DATA_WIDTH-1:0] insn;
    logic [TAG_WIDTH-1:0]  dst_tag;
    logic [TAG_WIDTH-1:0]  tag0;
    logic [DATA_WIDTH-1:0] data0;
    logic                  rdy0;
    logic [TAG_WIDTH-1:0]  tag1;
    logic [DATA_WIDTH-1:0] data1;
    logic                  rdy1;
  } entry_t;

  logic [RS_DEPTH-1:0] valid_q, valid_d;
  entry_t              ent_q [RS_DEPTH];
  entry_t              ent_d [RS_DEPTH];

  logic                  fu_valid_q;
  logic [OPC_W-1:0]      fu_opcode_q;
  logic [ADDR_WIDTH-1:0] fu_iaddr_q;
  logic [DATA_WIDTH-1:0] fu_insn_q;
  logic [DATA_WIDTH-1:0] fu_src_a_q;
  logic [DATA_WIDTH-1:0] fu_src_b_q;
  logic [TAG_WIDTH-1:0]  fu_tag_q;

  logic                flush_c, wake_c, stall_c, out_load_c;
  logic                sel_found_c, issue_c, enq_c;
  logic [IDX_W-1:0]    sel_idx_c, free_idx_c;
  logic [RS_DEPTH-1:0] ready_c;
  entry_t              new_ent_c;

  // A redirecting broadcast flushes; only a non-redirect broadcast wakes operands.
  assign flush_c    = cdb.i_cdb_en & cdb.i_cdb_redirect;
  assign wake_c     = cdb.i_cdb_en & ~cdb.i_cdb_redirect;
  assign stall_c    = &valid_q;
  assign out_load_c = ~fu_valid_q | ~fu.i_fu_stall;
  assign issue_c    = out_load_c & sel_found_c & ~flush_c;
  assign enq_c      = disp.i_rs_en & ~stall_c & ~flush_c;

  assign disp.o_rs_stall = stall_c;

  // Ready vector, lowest-index ready select and lowest-index free slot.
  always_comb begin
    ready_c     = '0;
    sel_found_c = 1'b0;
    sel_idx_c   = '0;
    free_idx_c  = '0;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      ready_c[i] = valid_q[i] & ent_q[i].rdy0 & ent_q[i].rdy1;
    end
    for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
      if (ready_c[i]) begin
        sel_found_c = 1'b1;
        sel_idx_c   = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_idx_c = IDX_W'(i);
      end
    end
  end

  // Incoming entry, with same-edge CDB bypass for operands still outstanding.
  always_comb begin
    new_ent_c         = '0;
    new_ent_c.opcode  = disp.i_rs_opcode;
    new_ent_c.iaddr   = disp.i_rs_iaddr;
    new_ent_c.insn    = disp.i_rs_insn;
    new_ent_c.dst_tag = disp.i_rs_dst_tag;
    new_ent_c.tag0    = disp.i_rs_src_tag0;
    new_ent_c.data0   = disp.i_rs_src_data0;
    new_ent_c.rdy0    = disp.i_rs_src_rdy0;
    new_ent_c.tag1    = disp.i_rs_src_tag1;
    new_ent_c.data1   = disp.i_rs_src_data1;
    new_ent_c.rdy1    = disp.i_rs_src_rdy1;
    if (wake_c && !disp.i_rs_src_rdy0 && (cdb.i_cdb_tag == disp.i_rs_src_tag0)) begin
      new_ent_c.data0 = cdb.i_cdb_data;
      new_ent_c.rdy0  = 1'b1;
    end
    if (wake_c && !disp.i_rs_src_rdy1 && (cdb.i_cdb_tag == disp.i_rs_src_tag1)) begin
      new_ent_c.data1 = cdb.i_cdb_data;
      new_ent_c.rdy1  = 1'b1;
    end
  end

  // Next entry state: wakeup, issue free, enqueue, then flush overrides all.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      ent_d[i] = ent_q[i];
      if (wake_c && valid_q[i] && !ent_q[i].rdy0 && (ent_q[i].tag0 == cdb.i_cdb_tag)) begin
        ent_d[i].data0 = cdb.i_cdb_data;
        ent_d[i].rdy0  = 1'b1;
      end
      if (wake_c && valid_q[i] && !ent_q[i].rdy1 && (ent_q[i].tag1 == cdb.i_cdb_tag)) begin
        ent_d[i].data1 = cdb.i_cdb_data;
        ent_d[i].rdy1  = 1'b1;
      end
    end
    if (issue_c) begin
      valid_d[sel_idx_c] = 1'b0;
    end
    if (enq_c) begin
      valid_d[free_idx_c] = 1'b1;
      ent_d[free_idx_c]   = new_ent_c;
    end
    if (flush_c) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(RS_DEPTH); i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < int'(RS_DEPTH); i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  // Issue register: holds under FU backpressure, cleared by flush.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fu_valid_q  <= 1'b0;
      fu_opcode_q <= '0;
      fu_iaddr_q  <= '0;
      fu_insn_q   <= '0;
      fu_src_a_q  <= '0;
      fu_src_b_q  <= '0;
      fu_tag_q    <= '0;
    end else if (flush_c) begin
      fu_valid_q <= 1'b0;
    end else if (out_load_c) begin
      fu_valid_q <= sel_found_c;
      if (sel_found_c) begin
        fu_opcode_q <= ent_q[sel_idx_c].opcode;
        fu_iaddr_q  <= ent_q[sel_idx_c].iaddr;
        fu_insn_q   <= ent_q[sel_idx_c].insn;
        fu_src_a_q  <= ent_q[sel_idx_c].data0;
        fu_src_b_q  <= ent_q[sel_idx_c].data1;
        fu_tag_q    <= ent_q[sel_idx_c].dst_tag;
      end
    end
  end

  assign fu.o_fu_valid  = fu_valid_q;
  assign fu.o_fu_opcode = fu_opcode_q;
  assign fu.o_fu_iaddr  = fu_iaddr_q;
  assign fu.o_fu_insn   = fu_insn_q;
  assign fu.o_fu_src_a  = fu_src_a_q;
  assign fu.o_fu_src_b  = fu_src_b_q;
  assign fu.o_fu_tag    = fu_tag_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: vector table for the single-flow
// cases, hand sequences for reset, FU backpressure and flush.

module tb_reservation_station;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  rs_dispatch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(6)) dif ();
  rs_cdb_if      #(.DATA_WIDTH(32), .TAG_WIDTH(6))                  cif ();
  rs_funit_if    #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(6)) fif ();

  reservation_station #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(6), .RS_DEPTH(4)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .disp  (dif.slave),
    .cdb   (cif.slave),
    .fu    (fif.master)
  );

  typedef struct {
    logic        en;
    logic [5:0]  t0;
    logic [31:0] d0;
    logic        r0;
    logic [5:0]  t1;
    logic [31:0] d1;
    logic        r1;
    logic [5:0]  dst;
    logic        cen;
    logic [5:0]  ctag;
    logic [31:0] cdata;
    logic        redir;
    logic        ev;
    logic        es;
    logic [5:0]  etag;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs [$];

  function automatic vec_t mk(
    input int unsigned en, input int unsigned t0, input int unsigned d0, input int unsigned r0,
    input int unsigned t1, input int unsigned d1, input int unsigned r1, input int unsigned dst,
    input int unsigned cen, input int unsigned ctag, input int unsigned cdata, input int unsigned redir,
    input int unsigned ev, input int unsigned es, input int unsigned etag,
    input int unsigned ea, input int unsigned eb);
    vec_t v;
    v.en = 1'(en); v.t0 = 6'(t0); v.d0 = 32'(d0); v.r0 = 1'(r0);
    v.t1 = 6'(t1); v.d1 = 32'(d1); v.r1 = 1'(r1); v.dst = 6'(dst);
    v.cen = 1'(cen); v.ctag = 6'(ctag); v.cdata = 32'(cdata); v.redir = 1'(redir);
    v.ev = 1'(ev); v.es = 1'(es); v.etag = 6'(etag); v.ea = 32'(ea); v.eb = 32'(eb);
    return v;
  endfunction

  // Dispatch side-band fields are derived from the destination tag.
  function automatic logic [6:0]  opc_of(input logic [5:0] d); return {1'b1, d}; endfunction
  function automatic logic [31:0] adr_of(input logic [5:0] d); return 32'h1000 + {24'h0, d, 2'b00}; endfunction
  function automatic logic [31:0] ins_of(input logic [5:0] d); return 32'hCAFE_0000 | {26'h0, d}; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_disp(input int unsigned en, input int unsigned dst,
                          input int unsigned t0, input int unsigned d0, input int unsigned r0,
                          input int unsigned t1, input int unsigned d1, input int unsigned r1);
    dif.i_rs_en        = 1'(en);
    dif.i_rs_dst_tag   = 6'(dst);
    dif.i_rs_opcode    = opc_of(6'(dst));
    dif.i_rs_iaddr     = adr_of(6'(dst));
    dif.i_rs_insn      = ins_of(6'(dst));
    dif.i_rs_src_tag0  = 6'(t0);
    dif.i_rs_src_data0 = 32'(d0);
    dif.i_rs_src_rdy0  = 1'(r0);
    dif.i_rs_src_tag1  = 6'(t1);
    dif.i_rs_src_data1 = 32'(d1);
    dif.i_rs_src_rdy1  = 1'(r1);
  endtask

  task automatic set_cdb(input int unsigned en, input int unsigned tag,
                         input int unsigned data, input int unsigned redir);
    cif.i_cdb_en       = 1'(en);
    cif.i_cdb_tag      = 6'(tag);
    cif.i_cdb_data     = 32'(data);
    cif.i_cdb_redirect = 1'(redir);
  endtask

  task automatic idle();
    set_disp(0, 0, 0, 0, 0, 0, 0, 0);
    set_cdb(0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_issue(input string name, input logic [5:0] tag,
                           input logic [31:0] a, input logic [31:0] b);
    chk({name, " valid"}, 32'(fif.o_fu_valid), 32'd1);
    chk({name, " tag"},   32'(fif.o_fu_tag), 32'(tag));
    chk({name, " src_a"}, fif.o_fu_src_a, a);
    chk({name, " src_b"}, fif.o_fu_src_b, b);
    chk({name, " opcode"}, 32'(fif.o_fu_opcode), 32'(opc_of(tag)));
    chk({name, " iaddr"}, fif.o_fu_iaddr, adr_of(tag));
    chk({name, " insn"},  fif.o_fu_insn, ins_of(tag));
  endtask

  initial begin
    idle();
    fif.i_fu_stall = 1'b0;

    // Reset values while held in reset.
    #1;
    chk("rst valid", 32'(fif.o_fu_valid), 32'd0);
    chk("rst stall", 32'(dif.o_rs_stall), 32'd0);
    chk("rst src_a", fif.o_fu_src_a, 32'd0);
    chk("rst tag",   32'(fif.o_fu_tag), 32'd0);
    #11 n_rst = 1'b1;

    //          en t0 d0        r0 t1 d1       r1 dst cen ctag cdata       rd ev es etag ea          eb
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(1, 0, 32'h11,    1, 0, 32'h22,   1, 3,  0, 0,  0,          0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 1, 0, 3,  32'h11,     32'h22));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(1, 5, 0,         0, 0, 32'h77,   1, 4,  0, 0,  0,          0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  1, 5,  32'hDEAD,   0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 1, 0, 4,  32'hDEAD,   32'h77));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(1, 5, 0,         0, 0, 32'h88,   1, 6,  1, 5,  32'hDEAD,   0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 1, 0, 6,  32'hDEAD,   32'h88));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(1, 9, 0,         0, 9, 0,        0, 10, 0, 0,  0,          0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(1, 9, 0,         0, 9, 0,        0, 11, 0, 0,  0,          0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(1, 9, 0,         0, 9, 0,        0, 12, 0, 0,  0,          0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(1, 9, 0,         0, 9, 0,        0, 13, 0, 0,  0,          0, 0, 1, 0,  0,          0));
    vecs.push_back(mk(1, 0, 32'hEE,    1, 0, 32'hEF,   1, 14, 0, 0,  0,          0, 0, 1, 0,  0,          0));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  1, 9,  32'h99,     0, 0, 1, 0,  0,          0));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 1, 0, 10, 32'h99,     32'h99));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 1, 0, 11, 32'h99,     32'h99));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 1, 0, 12, 32'h99,     32'h99));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 1, 0, 13, 32'h99,     32'h99));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 0, 0, 0,  0,          0));
    // Tag 41 differs from 9 only in the MSB: must not wake.
    vecs.push_back(mk(1, 9, 0,         0, 0, 32'h5,    1, 15, 0, 0,  0,          0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  1, 41, 32'hBAD,    0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  1, 9,  32'h1234,   0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 1, 0, 15, 32'h1234,   32'h5));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 0, 0, 0,  0,          0));
    // Enqueue and issue on the same edge.
    vecs.push_back(mk(1, 0, 32'h1,     1, 0, 32'h2,    1, 20, 0, 0,  0,          0, 0, 0, 0,  0,          0));
    vecs.push_back(mk(1, 0, 32'h3,     1, 0, 32'h4,    1, 21, 0, 0,  0,          0, 1, 0, 20, 32'h1,      32'h2));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 1, 0, 21, 32'h3,      32'h4));
    vecs.push_back(mk(0, 0, 0,         0, 0, 0,        0, 0,  0, 0,  0,          0, 0, 0, 0,  0,          0));

    foreach (vecs[k]) begin
      set_disp(vecs[k].en, vecs[k].dst, vecs[k].t0, vecs[k].d0, vecs[k].r0,
               vecs[k].t1, vecs[k].d1, vecs[k].r1);
      set_cdb(vecs[k].cen, vecs[k].ctag, vecs[k].cdata, vecs[k].redir);
      step();
      chk($sformatf("v%0d rs_stall", k), 32'(dif.o_rs_stall), 32'(vecs[k].es));
      if (vecs[k].ev)
        chk_issue($sformatf("v%0d", k), vecs[k].etag, vecs[k].ea, vecs[k].eb);
      else
        chk($sformatf("v%0d valid", k), 32'(fif.o_fu_valid), 32'd0);
    end
    idle();

    // FU backpressure holds the issued entry while a second one waits.
    set_disp(1, 30, 0, 32'h30, 1, 0, 32'h31, 1);
    step();
    chk("fs pre valid", 32'(fif.o_fu_valid), 32'd0);
    set_disp(1, 31, 0, 32'h40, 1, 0, 32'h41, 1);
    step();
    chk_issue("fs first", 6'd30, 32'h30, 32'h31);
    idle();
    fif.i_fu_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_issue($sformatf("fs hold%0d", c), 6'd30, 32'h30, 32'h31);
    end
    fif.i_fu_stall = 1'b0;
    step();
    chk_issue("fs second", 6'd31, 32'h40, 32'h41);
    step();
    chk("fs drain valid", 32'(fif.o_fu_valid), 32'd0);

    // Flush with a stalled output, three waiting entries and a colliding dispatch.
    set_disp(1, 40, 0, 32'h50, 1, 0, 32'h51, 1);
    step();
    set_disp(1, 41, 50, 0, 0, 0, 32'h1, 1);
    step();
    chk_issue("fl out", 6'd40, 32'h50, 32'h51);
    fif.i_fu_stall = 1'b1;
    set_disp(1, 42, 50, 0, 0, 0, 32'h2, 1);
    step();
    set_disp(1, 43, 50, 0, 0, 0, 32'h3, 1);
    step();
    chk("fl pre valid", 32'(fif.o_fu_valid), 32'd1);
    chk("fl pre stall", 32'(dif.o_rs_stall), 32'd0);
    set_disp(1, 44, 0, 32'h60, 1, 0, 32'h61, 1);
    set_cdb(1, 50, 32'h777, 1);
    step();
    chk("fl valid", 32'(fif.o_fu_valid), 32'd0);
    chk("fl stall", 32'(dif.o_rs_stall), 32'd0);
    fif.i_fu_stall = 1'b0;
    set_disp(0, 0, 0, 0, 0, 0, 0, 0);
    set_cdb(1, 50, 32'h888, 0);
    step();
    chk("fl post0 valid", 32'(fif.o_fu_valid), 32'd0);
    idle();
    for (int c = 1; c < 4; c++) begin
      step();
      chk($sformatf("fl post%0d valid", c), 32'(fif.o_fu_valid), 32'd0);
    end

    // Fill the station with a stalled FU, then reset asynchronously mid-cycle.
    fif.i_fu_stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_disp(1, 50 + c, 0, 32'h100 + c, 1, 0, 32'h200 + c, 1);
      step();
    end
    idle();
    chk_issue("ar pre", 6'd50, 32'h100, 32'h200);
    chk("ar pre stall", 32'(dif.o_rs_stall), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("ar valid", 32'(fif.o_fu_valid), 32'd0);
    chk("ar stall", 32'(dif.o_rs_stall), 32'd0);
    chk("ar src_a", fif.o_fu_src_a, 32'd0);
    chk("ar tag", 32'(fif.o_fu_tag), 32'd0);
    chk("ar opcode", 32'(fif.o_fu_opcode), 32'd0);
    #2 n_rst = 1'b1;
    fif.i_fu_stall = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("ar idle%0d valid", c), 32'(fif.o_fu_valid), 32'd0);
      chk($sformatf("ar idle%0d stall", c), 32'(dif.o_rs_stall), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
